wb_bus_stage: RTL and testbench
===============================

Name: wb_bus_stage

Overview:
- Writeback stage directly downstream of the MEM/WB pipeline register.
- Completes load/store bus transactions to the SoC slaves (data memory, UART, timer, GPIO, default slave), inserting wait states while a slave is not ready.
- Selects the writeback value from ALU, load data, HI, LO or CP0 and drives a registered register-file write port.
- Asserts stall while a transaction is outstanding, so upstream stages hold.

Parameters:
TIMEOUT, 16, wait cycles before an outstanding access is aborted (only with WB_BUS_TIMEOUT_EN).
DEFAULT_RDATA, 32'h0000_0000, read data returned on any default-slave/decode-error access.

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous, active-low reset
RegWriteW  input  1  instruction writes the register file
MemWriteW  input  1  instruction is a store
mfc0W  input  1  instruction is MFC0; CP0 value overrides the MemtoReg selection
MemtoRegW  input  2  00 ALU, 01 load data, 10 HI, 11 LO
ALUOutW  input  32  ALU result / bus address
WriteRegW  input  5  destination register
hi_rd_W  input  32  HI register value
lo_rd_W  input  32  LO register value
cp0_to_regfileW  input  32  CP0 read value
slave_en_W  input  5  one-hot slave select {gpio, default, timer, uart, dmem}
slave_rdata  input  128  packed read data {gpio, timer, uart, dmem}, 32 bits each
slave_ready  input  4  per-slave ready {gpio, timer, uart, dmem}
rf_we  output  1  register-file write enable (registered)
rf_waddr  output  5  register-file write address (registered)
rf_wdata  output  32  register-file write data (registered)
stall_wb  output  1  combinational; high = upstream must hold its outputs
bus_err  output  1  one-cycle pulse on decode error or timeout
err_addr  output  32  ALUOutW of the last errored access; holds until the next error

Behaviour:
- Reset (RST low, asynchronous): rf_we=0, rf_waddr=0, rf_wdata=0, bus_err=0, err_addr=0, state=IDLE, wait counter=0; stall_wb=0 as a consequence.
- An access is any cycle in which MemWriteW=1 or MemtoRegW=01.
- Decode error: access with slave_en_W not one-hot, zero, or equal to the default-slave bit.
  - Completes in the cycle it is presented.
  - Load data = DEFAULT_RDATA; bus_err pulses next cycle; err_addr <= ALUOutW.
  - The load still writes rf (rf_we as RegWriteW).
- Non-access instruction: writeback value captured every cycle:
  - rf_we <= RegWriteW, rf_waddr <= WriteRegW.
  - rf_wdata <= cp0_to_regfileW if mfc0W, else the value selected by MemtoRegW.
  - Latency is one cycle.
- IDLE, access with selected slave ready=1: zero wait states; completes as a non-access instruction, with load data = the selected slave's slave_rdata slice; stall_wb=0.
- IDLE, access with selected slave ready=0: stall_wb=1 combinationally; next state WAIT; counter cleared; rf_we <= 0.
- WAIT: stall_wb=1 each cycle ready is low; counter increments.
  - Ready high: stall_wb=0 that cycle, writeback captured as above, next state IDLE.
  - Upstream inputs are stable throughout WAIT (guaranteed by the stall).
- Stores never set rf_we, regardless of RegWriteW. A store completes on the slave's ready.
- The selected slave's ready/rdata are sampled only in the completing cycle; other slaves' ready is ignored.
- Reset asserted mid-WAIT aborts the transaction: no rf write, no bus_err.
- bus_err and a normal completion never occur in the same cycle.

Optional Feature:
- Macro WB_BUS_TIMEOUT_EN.
- Defined: in WAIT, when the counter reaches TIMEOUT-1 with ready still low, the access is aborted that cycle:
  - stall_wb=0, rf_we <= 0.
  - bus_err pulses next cycle; err_addr <= ALUOutW.
  - next state IDLE.
- Undefined: no counter logic; WAIT lasts until ready; bus_err arises only from decode errors.

Test Plan:
- Reset mid-WAIT (uart ready held 0, RST pulsed low) -> all outputs 0, state IDLE, stall_wb=0, no rf write after release.
- ALU op: RegWriteW=1, MemtoRegW=00, ALUOutW=0x1234, WriteRegW=5 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234, stall_wb never high; same with mfc0W=1, cp0=0xCAFE -> rf_wdata=0xCAFE.
- dmem load: slave_en_W=00001, dmem ready=1, rdata=0xA5A5A5A5 -> zero stall, next cycle rf_wdata=0xA5A5A5A5.
- UART load: ready low 3 cycles then high with rdata=0x41 -> stall_wb high exactly 3 cycles, rf write of 0x41 one cycle after ready.
- Decode error: load with slave_en_W=00011, ALUOutW=0xBFFF0000 -> no stall, bus_err one-cycle pulse, err_addr=0xBFFF0000, rf_wdata=DEFAULT_RDATA.
- WB_BUS_TIMEOUT_EN defined, TIMEOUT=16, timer never ready, store to 0x8000 -> stall_wb high 15 cycles, then bus_err pulse, err_addr=0x8000, rf_we stays 0.

Source files
------------

// File: rtl/wb_bus_stage.sv
// -----------------------------------------------------------------------------
// wb_bus_stage
//
// Writeback stage sitting after the MEM/WB pipeline register. It finishes
// load/store transactions to the SoC slaves (dmem, uart, timer, gpio, default),
// inserts wait states while the addressed slave is not ready, selects the
// writeback value and drives a registered register-file write port.
//
// Optional feature: define WB_BUS_TIMEOUT_EN to abort an access that is still
// waiting after TIMEOUT-1 stall cycles (reported through bus_err).
//
// Ports
//   CLK              clock, rising edge
//   RST              asynchronous active-low reset
//   RegWriteW        instruction writes the register file
//   MemWriteW        instruction is a store
//   mfc0W            MFC0: CP0 value overrides the MemtoReg selection
//   MemtoRegW        00 ALU, 01 load data, 10 HI, 11 LO
//   ALUOutW          ALU result / bus address
//   WriteRegW        destination register
//   hi_rd_W          HI register value
//   lo_rd_W          LO register value
//   cp0_to_regfileW  CP0 read value
//   slave_en_W       one-hot slave select {gpio, default, timer, uart, dmem}
//   slave_rdata      packed read data {gpio, timer, uart, dmem}
//   slave_ready      per-slave ready {gpio, timer, uart, dmem}
//   rf_we/rf_waddr/rf_wdata  registered register-file write port
//   stall_wb         combinational hold request to upstream stages
//   bus_err          one-cycle pulse on decode error or timeout
//   err_addr         address of the last errored access
// -----------------------------------------------------------------------------
module wb_bus_stage #(
  parameter int unsigned TIMEOUT       = 16,
  parameter logic [31:0] DEFAULT_RDATA = 32'h0000_0000
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         RegWriteW,
  input  logic         MemWriteW,
  input  logic         mfc0W,
  input  logic [1:0]   MemtoRegW,
  input  logic [31:0]  ALUOutW,
  input  logic [4:0]   WriteRegW,
  input  logic [31:0]  hi_rd_W,
  input  logic [31:0]  lo_rd_W,
  input  logic [31:0]  cp0_to_regfileW,
  input  logic [4:0]   slave_en_W,
  input  logic [127:0] slave_rdata,
  input  logic [3:0]   slave_ready,
  output logic         rf_we,
  output logic [4:0]   rf_waddr,
  output logic [31:0]  rf_wdata,
  output logic         stall_wb,
  output logic         bus_err,
  output logic [31:0]  err_addr
);

  // A timeout below 2 could never fire after the first stalled cycle.
  if (TIMEOUT < 2) begin : g_timeout_check
    $error("wb_bus_stage: TIMEOUT must be at least 2");
  end

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic        access;
  logic        dec_bad;
  logic        dec_err;
  logic        sel_ready;
  logic [31:0] sel_rdata;
  logic [31:0] load_data;
  logic [31:0] wb_val;
  logic        stall_int;
  logic        complete;
  logic        err_now;

  assign access = MemWriteW | (MemtoRegW == 2'b01);

  // Slave decode: only a single dmem/uart/timer/gpio bit is a legal select;
  // zero, multiple bits or the default-slave bit all count as decode errors.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    dec_bad   = 1'b0;
    case (slave_en_W)
      5'b00001: begin sel_ready = slave_ready[0]; sel_rdata = slave_rdata[31:0];   end
      5'b00010: begin sel_ready = slave_ready[1]; sel_rdata = slave_rdata[63:32];  end
      5'b00100: begin sel_ready = slave_ready[2]; sel_rdata = slave_rdata[95:64];  end
      5'b10000: begin sel_ready = slave_ready[3]; sel_rdata = slave_rdata[127:96]; end
      default:  dec_bad = 1'b1;
    endcase
  end

  assign dec_err   = access & dec_bad;
  assign load_data = dec_bad ? DEFAULT_RDATA : sel_rdata;

  always_comb begin
    wb_val = ALUOutW;
    if (mfc0W) begin
      wb_val = cp0_to_regfileW;
    end else begin
      case (MemtoRegW)
        2'b00:   wb_val = ALUOutW;
        2'b01:   wb_val = load_data;
        2'b10:   wb_val = hi_rd_W;
        default: wb_val = lo_rd_W;
      endcase
    end
  end

`ifdef WB_BUS_TIMEOUT_EN
  localparam int unsigned     CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  // Abort when the incremented count would reach TIMEOUT-1; together with
  // the IDLE cycle that first stalled this yields TIMEOUT-1 stall cycles.
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 2);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q <= '0;
    end else if (state_q == IDLE) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    stall_int = 1'b0;
    complete  = 1'b0;
    err_now   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!access) begin
          complete = 1'b1;
        end else if (dec_err) begin
          complete = 1'b1;
          err_now  = 1'b1;
        end else if (sel_ready) begin
          complete = 1'b1;
        end else begin
          stall_int = 1'b1;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (sel_ready) begin
          complete = 1'b1;
          state_d  = IDLE;
        end
`ifdef WB_BUS_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          err_now = 1'b1;
          state_d = IDLE;
        end
`endif
        else begin
          stall_int = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Held low during reset so upstream never sees a stall from stale inputs.
  assign stall_wb = stall_int & RST;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      bus_err  <= 1'b0;
      err_addr <= '0;
    end else begin
      state_q  <= state_d;
      rf_we    <= complete & RegWriteW & ~MemWriteW;
      rf_waddr <= WriteRegW;
      rf_wdata <= wb_val;
      bus_err  <= err_now;
      if (err_now) begin
        err_addr <= ALUOutW;
      end
    end
  end

endmodule

// File: tb/tb_wb_bus_stage.sv
module tb_wb_bus_stage;

  logic         CLK = 1'b0;
  logic         RST;
  logic         RegWriteW, MemWriteW, mfc0W;
  logic [1:0]   MemtoRegW;
  logic [31:0]  ALUOutW, hi_rd_W, lo_rd_W, cp0_to_regfileW;
  logic [4:0]   WriteRegW, slave_en_W;
  logic [127:0] slave_rdata;
  logic [3:0]   slave_ready;
  logic         rf_we, stall_wb, bus_err;
  logic [4:0]   rf_waddr;
  logic [31:0]  rf_wdata, err_addr;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        we;
    logic        err;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] eaddr;
  } exp_t;

  exp_t q[$];
  logic [31:0] last_err = '0;

  wb_bus_stage #(.TIMEOUT(16), .DEFAULT_RDATA(32'h0000_0000)) dut (
    .CLK(CLK), .RST(RST),
    .RegWriteW(RegWriteW), .MemWriteW(MemWriteW), .mfc0W(mfc0W),
    .MemtoRegW(MemtoRegW), .ALUOutW(ALUOutW), .WriteRegW(WriteRegW),
    .hi_rd_W(hi_rd_W), .lo_rd_W(lo_rd_W), .cp0_to_regfileW(cp0_to_regfileW),
    .slave_en_W(slave_en_W), .slave_rdata(slave_rdata), .slave_ready(slave_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .stall_wb(stall_wb), .bus_err(bus_err), .err_addr(err_addr)
  );

  always #5 CLK = ~CLK;

  function automatic exp_t mk(input logic we, input logic err, input logic [4:0] wa,
                              input logic [31:0] wd, input logic [31:0] ea);
    exp_t e;
    e.we = we; e.err = err; e.waddr = wa; e.wdata = wd; e.eaddr = ea;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic nop();
    RegWriteW = 0; MemWriteW = 0; mfc0W = 0; MemtoRegW = 2'b00;
    ALUOutW = '0; WriteRegW = '0; cp0_to_regfileW = '0;
    slave_en_W = '0; slave_rdata = '0; slave_ready = '1;
  endtask

  // Presents one instruction; ready of slave ridx rises after n_wait cycles.
  task automatic run_op(input string name, input logic rw, input logic mw, input logic mf,
                        input logic [1:0] m2r, input logic [31:0] alu, input logic [4:0] wr,
                        input logic [31:0] cp0, input logic [4:0] en, input int ridx,
                        input logic [31:0] rd, input int n_wait, input int exp_stall,
                        input logic push, input exp_t e);
    RegWriteW = rw; MemWriteW = mw; mfc0W = mf; MemtoRegW = m2r;
    ALUOutW = alu; WriteRegW = wr; cp0_to_regfileW = cp0; slave_en_W = en;
    slave_ready = '1;
    slave_rdata = {4{32'hDEAD_BEEF}};
    if (ridx >= 0) begin
      if (n_wait > 0) slave_ready[ridx] = 1'b0;
      else slave_rdata[ridx*32 +: 32] = rd;
    end
    if (push) q.push_back(e);
    for (int k = 0; k <= exp_stall; k++) begin
      @(negedge CLK);
      chk({name, "_stall"}, {31'd0, stall_wb}, {31'd0, (k < exp_stall)});
      @(posedge CLK); #2;
      if (ridx >= 0 && k + 1 == n_wait) begin
        slave_ready[ridx] = 1'b1;
        slave_rdata[ridx*32 +: 32] = rd;
      end
    end
    nop();
  endtask

  // Scoreboard monitor: every write or error the DUT presents must match the
  // next queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK); #1;
      if (rf_we === 1'b1 || bus_err === 1'b1) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_output: rf_we=%b waddr=%0d wdata=0x%08h bus_err=%b err_addr=0x%08h required none",
                   rf_we, rf_waddr, rf_wdata, bus_err, err_addr);
        end else begin
          e = q.pop_front();
          if (rf_we !== e.we || bus_err !== e.err ||
              (e.we && (rf_waddr !== e.waddr || rf_wdata !== e.wdata)) ||
              (e.err && err_addr !== e.eaddr)) begin
            fails++;
            $display("FAIL scoreboard: got we=%b waddr=%0d wdata=0x%08h err=%b eaddr=0x%08h required we=%b waddr=%0d wdata=0x%08h err=%b eaddr=0x%08h",
                     rf_we, rf_waddr, rf_wdata, bus_err, err_addr,
                     e.we, e.waddr, e.wdata, e.err, e.eaddr);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    hi_rd_W = 32'h1111_2222;
    lo_rd_W = 32'h3333_4444;
    nop();
    RST = 1'b0;
    #12;
    chk("reset_rf_we", {31'd0, rf_we}, 32'd0);
    chk("reset_rf_waddr", {27'd0, rf_waddr}, 32'd0);
    chk("reset_rf_wdata", rf_wdata, 32'd0);
    chk("reset_bus_err", {31'd0, bus_err}, 32'd0);
    chk("reset_err_addr", err_addr, 32'd0);
    chk("reset_stall", {31'd0, stall_wb}, 32'd0);
    @(posedge CLK); #2;
    RST = 1'b1;

    run_op("alu", 1, 0, 0, 2'b00, 32'h1234, 5'd5, 32'h0, 5'b00000, -1, 32'h0, 0, 0,
           1, mk(1, 0, 5'd5, 32'h1234, 32'h0));
    run_op("mfc0", 1, 0, 1, 2'b00, 32'h1234, 5'd6, 32'hCAFE, 5'b00000, -1, 32'h0, 0, 0,
           1, mk(1, 0, 5'd6, 32'hCAFE, 32'h0));
    run_op("hi", 1, 0, 0, 2'b10, 32'h9, 5'd7, 32'h0, 5'b00000, -1, 32'h0, 0, 0,
           1, mk(1, 0, 5'd7, 32'h1111_2222, 32'h0));
    run_op("lo", 1, 0, 0, 2'b11, 32'h9, 5'd8, 32'h0, 5'b00000, -1, 32'h0, 0, 0,
           1, mk(1, 0, 5'd8, 32'h3333_4444, 32'h0));
    run_op("nowrite", 0, 0, 0, 2'b00, 32'h55, 5'd3, 32'h0, 5'b00000, -1, 32'h0, 0, 0,
           0, mk(0, 0, 5'd0, 32'h0, 32'h0));
    run_op("dmem_load", 1, 0, 0, 2'b01, 32'h0000_0100, 5'd9, 32'h0, 5'b00001, 0, 32'hA5A5_A5A5, 0, 0,
           1, mk(1, 0, 5'd9, 32'hA5A5_A5A5, 32'h0));
    run_op("uart_load", 1, 0, 0, 2'b01, 32'h1000_0000, 5'd10, 32'h0, 5'b00010, 1, 32'h41, 3, 3,
           1, mk(1, 0, 5'd10, 32'h41, 32'h0));
    run_op("decerr_load", 1, 0, 0, 2'b01, 32'hBFFF_0000, 5'd11, 32'h0, 5'b00011, -1, 32'h0, 0, 0,
           1, mk(1, 1, 5'd11, 32'h0, 32'hBFFF_0000));
    last_err = 32'hBFFF_0000;
    run_op("timer_load", 1, 0, 0, 2'b01, 32'h2000_0000, 5'd13, 32'h0, 5'b00100, 2, 32'h7777_0001, 0, 0,
           1, mk(1, 0, 5'd13, 32'h7777_0001, 32'h0));
    chk("err_addr_hold", err_addr, last_err);
    run_op("gpio_store", 1, 1, 0, 2'b00, 32'h4000_0000, 5'd14, 32'h0, 5'b10000, 3, 32'h0, 2, 2,
           0, mk(0, 0, 5'd0, 32'h0, 32'h0));
    run_op("gpio_load", 1, 0, 0, 2'b01, 32'h4000_0004, 5'd15, 32'h0, 5'b10000, 3, 32'h0000_00F0, 1, 1,
           1, mk(1, 0, 5'd15, 32'h0000_00F0, 32'h0));
    run_op("default_store", 1, 1, 0, 2'b00, 32'h3000_0000, 5'd16, 32'h0, 5'b01000, -1, 32'h0, 0, 0,
           1, mk(0, 1, 5'd0, 32'h0, 32'h3000_0000));
    last_err = 32'h3000_0000;
    run_op("zero_sel_load", 0, 0, 0, 2'b01, 32'h0000_0040, 5'd17, 32'h0, 5'b00000, -1, 32'h0, 0, 0,
           1, mk(0, 1, 5'd0, 32'h0, 32'h0000_0040));
    last_err = 32'h0000_0040;

    // Reset in the middle of a uart wait.
    RegWriteW = 1; MemtoRegW = 2'b01; ALUOutW = 32'h1000_0000; WriteRegW = 5'd12;
    slave_en_W = 5'b00010; slave_rdata = {4{32'hDEAD_BEEF}}; slave_ready = 4'b1101;
    @(negedge CLK);
    chk("rstwait_stall_idle", {31'd0, stall_wb}, 32'd1);
    @(posedge CLK); #2;
    @(negedge CLK);
    chk("rstwait_stall_wait", {31'd0, stall_wb}, 32'd1);
    #2 RST = 1'b0;
    #1;
    chk("rstwait_rf_we", {31'd0, rf_we}, 32'd0);
    chk("rstwait_rf_waddr", {27'd0, rf_waddr}, 32'd0);
    chk("rstwait_rf_wdata", rf_wdata, 32'd0);
    chk("rstwait_bus_err", {31'd0, bus_err}, 32'd0);
    chk("rstwait_err_addr", err_addr, 32'd0);
    chk("rstwait_stall", {31'd0, stall_wb}, 32'd0);
    last_err = '0;
    @(posedge CLK); #2;
    nop();
    @(posedge CLK); #2;
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("post_reset_stall", {31'd0, stall_wb}, 32'd0);
    @(posedge CLK); #2;

    run_op("alu_after_reset", 1, 0, 0, 2'b00, 32'h0BAD_F00D, 5'd31, 32'h0, 5'b00000, -1, 32'h0, 0, 0,
           1, mk(1, 0, 5'd31, 32'h0BAD_F00D, 32'h0));

`ifdef WB_BUS_TIMEOUT_EN
    run_op("timeout_store", 1, 1, 0, 2'b00, 32'h0000_8000, 5'd4, 32'h0, 5'b00100, 2, 32'h0, 1000, 15,
           1, mk(0, 1, 5'd0, 32'h0, 32'h0000_8000));
    last_err = 32'h0000_8000;
`endif

    repeat (3) @(posedge CLK);
    #3;
    chk("queue_drained", q.size(), 32'd0);
    chk("final_err_addr", err_addr, last_err);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
